// File: rtl/display_page_sched.sv
// Page scheduler for the 4-digit display: picks one of four 16-bit requester
// pages by dwell timer or debounced button and drives it onto the digit bus.
module display_page_sched #(
    parameter int DWELL    = 50_000_000,
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] page0,
    input  logic [15:0] page1,
    input  logic [15:0] page2,
    input  logic [15:0] page3,
    input  logic [3:0]  valid,
    input  logic        auto_en,
    input  logic        btn_next,
    output logic [15:0] digit,
    output logic [1:0]  page_idx,
    output logic        page_strobe,
    output logic        idle
);

    localparam int DW_W = $clog2(DWELL);
    localparam int DB_W = $clog2(DEBOUNCE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     digit_q, digit_d;
    logic            strobe_q, strobe_d;
    logic            idle_q, idle_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic [15:0]     pages_s [4];
    logic            advance_s;
    logic [1:0]      next_idx_s;

    // Round-robin search starting after cur; starting from 3 yields the lowest valid index.
    function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] v);
        logic [1:0] r;
        logic [1:0] cand;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = cur + 2'(k);
            if (!found && v[cand]) begin
                r     = cand;
                found = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Gather the requester pages into an indexable array.
    always_comb begin
        pages_s[0] = page0;
        pages_s[1] = page1;
        pages_s[2] = page2;
        pages_s[3] = page3;
    end

    // Debounce: accept the synchronized level only after it has been stable long enough.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (sync2_q != deb_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                deb_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Page FSM: entry, advance (timer, button or lost page) and exit to IDLE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        digit_d    = 16'h0000;
        strobe_d   = 1'b0;
        dwell_d    = '0;
        advance_s  = 1'b0;
        next_idx_s = rr_next(idx_q, valid);
        case (state_q)
            ST_IDLE: begin
                if (valid != 4'b0000) begin
                    state_d  = ST_SHOW;
                    idx_d    = rr_next(2'd3, valid);
                    strobe_d = 1'b1;
                    digit_d  = pages_s[idx_d];
                end else begin
                    digit_d = 16'h0000;
                end
            end
            ST_SHOW: begin
                if (valid == 4'b0000) begin
                    state_d = ST_IDLE;
                    digit_d = 16'h0000;
                end else begin
                    advance_s = !valid[idx_q] || press_q ||
                                (auto_en && (dwell_q == DW_W'(DWELL - 1)));
                    if (advance_s) begin
                        // Sole valid page: index stays, only the dwell restarts.
                        idx_d    = next_idx_s;
                        strobe_d = (next_idx_s != idx_q);
                        dwell_d  = '0;
                    end else if (auto_en) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end else begin
                        dwell_d = '0;
                    end
                    digit_d = pages_s[idx_d];
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = 16'h0000;
            end
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    // State, output and button-path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            digit_q  <= 16'h0000;
            strobe_q <= 1'b0;
            idle_q   <= 1'b1;
            dwell_q  <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            digit_q  <= digit_d;
            strobe_q <= strobe_d;
            idle_q   <= idle_d;
            dwell_q  <= dwell_d;
            sync1_q  <= btn_next;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    assign digit       = digit_q;
    assign page_idx    = idx_q;
    assign page_strobe = strobe_q;
    assign idle        = idle_q;

endmodule

// File: doc/display_page_sched.md
# display_page_sched

Page scheduler in front of the 4-digit seven-segment display driver. It shares the single 16-bit `digit` bus between four requesters, e.g. operand A, operand B, product high and product low of the multiplier. Pages are rotated round-robin on a dwell timer or advanced by a debounced pushbutton, skipping pages whose requester is not valid. The output feeds the display driver's 16-bit digit input directly.

## Interface
- `DWELL`, 50_000_000: cycles each page is shown in auto mode (≥2)
- `DEBOUNCE`, 1_000_000: cycles the synchronized button must be stable before acceptance (≥2)
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `page0`..`page3` in 16 each: requester data, four hex nibbles
- `valid` in 4: `valid[i]`=1 means page i may be shown
- `auto_en` in 1: 1 = timed rotation enabled
- `btn_next` in 1: raw pushbutton, asynchronous, active-high
- `digit` out 16: registered data to the display driver
- `page_idx` out 2: index of the page currently shown
- `page_strobe` out 1: one-cycle pulse after every page change
- `idle` out 1: high while no page is valid

## Operation
- Reset values: `digit`=16'h0000, `page_idx`=0, `page_strobe`=0, `idle`=1, state IDLE, all counters 0, debounced level 0, sync flops 0.
- FSM has two states, IDLE and SHOW.
  - IDLE: `digit`=0, `idle`=1, `page_idx` holds its value. When `valid`≠0, go to SHOW with `page_idx` = the lowest valid index, and pulse `page_strobe`.
  - SHOW: every cycle `digit` <= `page[page_idx_next]`. Live data is tracked, not snapshotted.
  - SHOW → IDLE when `valid`==0. `digit` clears on the same edge.
- Advance event = dwell expiry OR accepted button press. Simultaneous events produce one advance only.
- Next index on advance: search round-robin from `page_idx`+1 (mod 4) for the first set `valid` bit.
  - If the current page is the only valid one: index unchanged, no strobe, dwell counter restarts.
- Current page invalidated while in SHOW (other pages still valid): forced advance on the next edge, independent of timer and button.
- Dwell counter:
  - Counts 0..DWELL-1 in SHOW while `auto_en`=1.
  - Expiry is the edge on which it equals DWELL-1.
  - Resets to 0 on any page change, on entry to SHOW, and whenever `auto_en`=0.
- Button path:
  - Two-flop synchronizer drives the debounce counter.
  - The counter increments while the synchronized level differs from the debounced level, and clears when they are equal.
  - At DEBOUNCE-1 the debounced level takes the synchronized value.
  - A 0→1 transition of the debounced level sets a one-cycle press flag. Release produces no event.
  - Presses in IDLE are discarded.
- `page_strobe` is high for exactly one cycle, the cycle after `page_idx` changes or IDLE→SHOW entry.

## Timing
- Data latency: `pageN` change → `digit` updates at the next edge (1 cycle).
- Auto mode: each page is held exactly DWELL cycles, measured from the edge where `page_idx` changed.
- Button: `btn_next` rises and stays high → `page_idx` changes on the (DEBOUNCE+3)th rising edge. Any bounce restarts the count.
- `valid` change → IDLE/SHOW transition and `digit` update on the next edge.
- `rst_n` low mid-dwell or mid-debounce: all state returns to reset values immediately. After release, the first edge evaluates `valid` from IDLE.
- `page_idx` and `digit` are always updated on the same edge, so they never disagree.

## Test plan
Parameters for all tests: DWELL=8, DEBOUNCE=4.
- Reset, then `valid`=4'b1111, `auto_en`=1, `page0..3`=16'h1111/2222/3333/4444 → `digit` sequence 1111, 2222, 3333, 4444, 1111, each held 8 cycles. `page_strobe` pulses 1 cycle at each change. `idle` deasserts 1 cycle after `valid` is set.
- `valid`=4'b1010, `auto_en`=1 → `page_idx` alternates 1, 3, 1. Then clear `valid[3]` while on page 3 → `page_idx`=1 on the next edge.
- `auto_en`=0, `btn_next` held high from edge 0 → `page_idx` 0→1 on edge 7. A glitch of 1 high / 1 low / held high → change occurs 7 edges after the final rise. Release → no further advance.
- Only `valid[2]` set, `auto_en`=1 for 40 cycles → `page_idx` stays 2 and `page_strobe` never pulses. `page2` changed to 16'hBEEF → `digit`=BEEF one cycle later.
- Accepted press on the same edge as dwell expiry, `valid`=4'b1111, on page 0 → `page_idx`=1, not 2.
- `rst_n` pulsed low at dwell count 5 on page 2 → `digit`=0, `page_idx`=0 and `idle`=1 asynchronously. After release with `valid`=4'b1111 → `page_idx`=0, followed by a full 8-cycle dwell.
